// File: rtl/hazard_scoreboard.sv
// ID-stage hazard and forwarding controller: tracks in-flight writers in a shift
// scoreboard, flags stalls, picks forwarding stages and counts stall cycles.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 4,
    parameter int PIPE_DEPTH = 2,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16,
    localparam int FWD_W     = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_Issue_Valid,
    input  logic [REG_ADDR_W-1:0] i_Dest,
    input  logic                  i_Sig_Write_Back_Enable,
    input  logic                  i_Sig_Memory_Read_Enable,
    input  logic [REG_ADDR_W-1:0] i_Src_1,
    input  logic [REG_ADDR_W-1:0] i_Src_2,
    input  logic                  i_Two_Src,
    input  logic                  i_Sig_Forward_Enable,
    input  logic                  i_Freeze,
    input  logic                  i_Flush,
    input  logic                  i_Count_Clear,
    output logic                  o_Sig_Hazard_Detected,
    output logic [FWD_W-1:0]      o_Fwd_Sel_1,
    output logic [FWD_W-1:0]      o_Fwd_Sel_2,
    output logic [CNT_W-1:0]      o_Stall_Count
);

    logic [PIPE_DEPTH-1:0]                 valid_r;
    logic [PIPE_DEPTH-1:0]                 wb_r;
    logic [PIPE_DEPTH-1:0]                 mem_r;
    logic [PIPE_DEPTH-1:0][REG_ADDR_W-1:0] dest_r;
    logic [CNT_W-1:0]                      cnt_r;

    logic [PIPE_DEPTH-1:0] m1_s;
    logic [PIPE_DEPTH-1:0] m2_s;
    logic [PIPE_DEPTH-1:0] ld_mask_s;
    logic                  raw_hazard_s;
    logic                  hazard_s;
    logic                  push_s;
    logic [FWD_W-1:0]      sel1_s;
    logic [FWD_W-1:0]      sel2_s;

    // Source/destination matches per stage, and stages whose load data is not yet forwardable
    always_comb begin
        m1_s      = '0;
        m2_s      = '0;
        ld_mask_s = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            m1_s[k]      = valid_r[k] & wb_r[k] & (i_Src_1 == dest_r[k]);
            m2_s[k]      = valid_r[k] & wb_r[k] & i_Two_Src & (i_Src_2 == dest_r[k]);
            ld_mask_s[k] = mem_r[k] & (k < LOAD_LAT);
        end
    end

    // Stall decision: forward mode only stalls on loads still too young to forward
    always_comb begin
        raw_hazard_s = 1'b0;
        if (i_Sig_Forward_Enable) begin
            raw_hazard_s = |((m1_s | m2_s) & ld_mask_s);
        end else begin
            raw_hazard_s = |(m1_s | m2_s);
        end
        hazard_s = raw_hazard_s & i_Issue_Valid & ~i_Flush;
        push_s   = i_Issue_Valid & ~i_Flush & ~hazard_s;
    end

    // Forward selects: scan oldest to youngest so the youngest matching writer wins
    always_comb begin
        sel1_s = '0;
        sel2_s = '0;
        if (i_Sig_Forward_Enable && !hazard_s) begin
            for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
                if (m1_s[k]) begin
                    sel1_s = FWD_W'(k + 1);
                end else begin
                    sel1_s = sel1_s;
                end
                if (m2_s[k]) begin
                    sel2_s = FWD_W'(k + 1);
                end else begin
                    sel2_s = sel2_s;
                end
            end
        end else begin
            sel1_s = '0;
            sel2_s = '0;
        end
    end

    // Scoreboard shift register; held as a whole while the pipeline is frozen
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= '0;
            wb_r    <= '0;
            mem_r   <= '0;
            dest_r  <= '0;
        end else if (!i_Freeze) begin
            valid_r[0] <= push_s;
            wb_r[0]    <= push_s & i_Sig_Write_Back_Enable;
            mem_r[0]   <= push_s & i_Sig_Memory_Read_Enable;
            dest_r[0]  <= push_s ? i_Dest : {REG_ADDR_W{1'b0}};
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                valid_r[k] <= valid_r[k-1];
                wb_r[k]    <= wb_r[k-1];
                mem_r[k]   <= mem_r[k-1];
                dest_r[k]  <= dest_r[k-1];
            end
        end
    end

    // Saturating stall counter; clear wins over increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (i_Count_Clear) begin
            cnt_r <= '0;
        end else if (hazard_s && !i_Freeze && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_Sig_Hazard_Detected = hazard_s;
    assign o_Fwd_Sel_1           = sel1_s;
    assign o_Fwd_Sel_2           = sel2_s;
    assign o_Stall_Count         = cnt_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed scenarios plus random traffic
// checked against a list-of-in-flight-writers reference model.
module tb_hazard_scoreboard;

    localparam int RW   = 4;
    localparam int PD   = 2;
    localparam int LL   = 1;
    localparam int CW   = 4;
    localparam int FW   = $clog2(PD + 1);
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          issue_valid, wb_en, mem_rd, two_src, fwd_en, freeze, flush, cnt_clr;
    logic [RW-1:0] dest, src1, src2;
    logic          hazard;
    logic [FW-1:0] sel1, sel2;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_ADDR_W(RW), .PIPE_DEPTH(PD), .LOAD_LAT(LL), .CNT_W(CW)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .i_Issue_Valid            (issue_valid),
        .i_Dest                   (dest),
        .i_Sig_Write_Back_Enable  (wb_en),
        .i_Sig_Memory_Read_Enable (mem_rd),
        .i_Src_1                  (src1),
        .i_Src_2                  (src2),
        .i_Two_Src                (two_src),
        .i_Sig_Forward_Enable     (fwd_en),
        .i_Freeze                 (freeze),
        .i_Flush                  (flush),
        .i_Count_Clear            (cnt_clr),
        .o_Sig_Hazard_Detected    (hazard),
        .o_Fwd_Sel_1              (sel1),
        .o_Fwd_Sel_2              (sel2),
        .o_Stall_Count            (stall_cnt)
    );

    typedef struct { int dest; bit wb; bit ld; int stage; } wr_t;
    typedef struct { int hz; int s1; int s2; int cnt; } exp_t;

    wr_t  inflight[$];
    exp_t expq[$];
    exp_t mon_e;
    int   model_cnt;
    bit   cur_hz;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: one expected record per driven cycle, compared mid-cycle
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            check("sb_hazard", int'(hazard), mon_e.hz);
            check("sb_sel1", int'(sel1), mon_e.s1);
            check("sb_sel2", int'(sel2), mon_e.s2);
            check("sb_count", int'(stall_cnt), mon_e.cnt);
        end
    end

    task automatic drive(input bit v, input int d, input bit wb, input bit ld,
                         input int s1, input int s2, input bit two, input bit fwd,
                         input bit frz, input bit fl, input bit clr);
        bit   raw;
        int   best1, best2;
        exp_t e;
        issue_valid = v;  dest = RW'(d);  wb_en = wb;  mem_rd = ld;
        src1 = RW'(s1);   src2 = RW'(s2); two_src = two; fwd_en = fwd;
        freeze = frz;     flush = fl;     cnt_clr = clr;
        raw = 1'b0;  best1 = PD + 1;  best2 = PD + 1;
        foreach (inflight[i]) begin
            bit h1, h2;
            h1 = inflight[i].wb && (inflight[i].dest == s1);
            h2 = inflight[i].wb && two && (inflight[i].dest == s2);
            if (h1 || h2) begin
                if (!fwd) raw = 1'b1;
                else if (inflight[i].ld && inflight[i].stage < LL) raw = 1'b1;
            end
            if (h1 && inflight[i].stage < best1) best1 = inflight[i].stage;
            if (h2 && inflight[i].stage < best2) best2 = inflight[i].stage;
        end
        cur_hz = raw && v && !fl;
        e.hz  = int'(cur_hz);
        e.s1  = (fwd && !cur_hz && best1 < PD) ? best1 + 1 : 0;
        e.s2  = (fwd && !cur_hz && best2 < PD) ? best2 + 1 : 0;
        e.cnt = model_cnt;
        expq.push_back(e);
    endtask

    task automatic step();
        wr_t nxt[$];
        @(posedge clk);
        if (!freeze) begin
            foreach (inflight[i]) begin
                if (inflight[i].stage + 1 < PD) begin
                    wr_t w;
                    w = inflight[i];
                    w.stage = w.stage + 1;
                    nxt.push_back(w);
                end
            end
            if (issue_valid && !flush && !cur_hz)
                nxt.push_back('{int'(dest), wb_en, mem_rd, 0});
            inflight = nxt;
        end
        if (cnt_clr) model_cnt = 0;
        else if (cur_hz && !freeze && model_cnt < CMAX) model_cnt++;
        #1;
    endtask

    task automatic idle(input int n, input bit clr);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, clr);
            step();
        end
    endtask

    initial begin
        reset = 1'b0;
        model_cnt = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expq.delete();
        #2;
        check("reset_hazard", int'(hazard), 0);
        check("reset_sel1", int'(sel1), 0);
        check("reset_count", int'(stall_cnt), 0);
        #10 reset = 1'b1;
        @(posedge clk); #1;

        // 1: stall-only dependency
        idle(1, 1);
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0);
            #1 check("t1_hazard", int'(hazard), (i < 2) ? 1 : 0);
            step();
        end
        check("t1_count", int'(stall_cnt), 2);

        // 2: forwarding from stage 0 then stage 1
        idle(2, 1);
        drive(1, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0); step();
        drive(1, 4, 1, 0, 0, 3, 1, 1, 0, 0, 0);
        #1 check("t2_hazard", int'(hazard), 0);
        check("t2_sel2", int'(sel2), 1);
        step();
        drive(1, 5, 1, 0, 3, 0, 0, 1, 0, 0, 0);
        #1 check("t2_sel1", int'(sel1), 2);
        step();

        // 3: load-use stalls one cycle, then forwards from stage 1
        idle(2, 1);
        drive(1, 2, 1, 1, 0, 0, 0, 1, 0, 0, 0); step();
        drive(1, 6, 1, 0, 2, 0, 0, 1, 0, 0, 0);
        #1 check("t3_hazard", int'(hazard), 1);
        step();
        drive(1, 6, 1, 0, 2, 0, 0, 1, 0, 0, 0);
        #1 check("t3_hazard_after", int'(hazard), 0);
        check("t3_sel1", int'(sel1), 2);
        step();
        check("t3_count", int'(stall_cnt), 1);
        idle(2, 0);
        drive(1, 2, 1, 1, 0, 0, 0, 1, 0, 0, 0); step();
        drive(1, 6, 1, 0, 0, 2, 0, 1, 0, 0, 0);
        #1 check("t3_one_src_hazard", int'(hazard), 0);
        step();

        // 4: youngest writer wins, then counter saturation
        idle(2, 0);
        drive(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0); step();
        drive(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0); step();
        drive(1, 7, 1, 0, 5, 0, 0, 1, 0, 0, 0);
        #1 check("t4_youngest", int'(sel1), 1);
        step();
        idle(1, 1);
        for (int i = 0; i < 30; i++) begin
            drive(1, 5, 1, 0, 5, 0, 0, 0, 0, 0, 0); step();
        end
        check("t4_saturate", int'(stall_cnt), CMAX);

        // 5: freeze during a stall, then flush
        idle(2, 1);
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); step();
        drive(1, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0); step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 2, 1, 0, 1, 0, 0, 0, 1, 0, 0);
            #1 check("t5_frz_hazard", int'(hazard), 1);
            check("t5_frz_count", int'(stall_cnt), 1);
            step();
        end
        drive(1, 2, 1, 0, 1, 0, 0, 0, 0, 1, 0);
        #1 check("t5_flush_hazard", int'(hazard), 0);
        step();
        drive(1, 3, 1, 0, 2, 0, 0, 1, 0, 0, 0);
        #1 check("t5_bubble_sel1", int'(sel1), 0);
        step();

        // 6: asynchronous reset mid-stall
        idle(2, 0);
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); step();
        drive(1, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        #5 reset = 1'b0;
        #1 check("t6_hazard", int'(hazard), 0);
        check("t6_sel1", int'(sel1), 0);
        check("t6_count", int'(stall_cnt), 0);
        inflight.delete();
        model_cnt = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        #1 check("t6_no_match", int'(hazard), 0);
        step();

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            bit frz;
            frz = ($urandom_range(0, 9) == 0);
            drive($urandom_range(0, 4) != 0, $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, frz,
                  $urandom_range(0, 9) == 0, !frz && ($urandom_range(0, 19) == 0));
            step();
        end

        idle(1, 0);
        #10;
        check("drain", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
